// File: rtl/unidade_controle_pkg.sv
// unidade_controle_pkg
//   Shared definitions for the game control unit. The state encoding is the
//   value shown on db_estado, so the same constants serve the FSM and the
//   debug display decoding.
package unidade_controle_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hC,
        FIM_ERRO    = 4'hE
    } estado_t;

    // Width of the debug state code.
    localparam int ESTADO_W = 4;

endpackage : unidade_controle_pkg

// File: rtl/unidade_controle.sv
// unidade_controle
//   Moore FSM that sequences a 16-jogada memory game: it waits for each
//   jogada, registers it, compares it against the ROM word and either
//   advances, finishes with success, or finishes with an error/timeout.
//
// Parameters
//   TIMEOUT_EN   1: fimT in espera ends the game; 0: fimT is ignored
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset to inicial
//   iniciar      in   start request (level)
//   jogada_feita in   one-cycle pulse, a jogada has been made
//   igual        in   ROM word equals registered jogada
//   fimC         in   address counter at last position
//   fimT         in   timeout counter terminal count
//   zeraC        out  clear address and timeout counters
//   contaC       out  increment address counter
//   zeraR        out  clear jogada register
//   registraR    out  load jogada register
//   conta        out  enable timeout counter
//   pronto       out  game finished
//   acertou      out  finished with all jogadas correct
//   errou        out  finished by wrong jogada or timeout
//   timeout      out  finished by timeout
//   db_estado    out  current state code (debug)
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    input  logic       fimT,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t next_estado;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= next_estado;
        end
    end

    // Next-state logic
    always_comb begin
        next_estado = estado;
        case (estado)
            INICIAL:     if (iniciar) next_estado = PREPARACAO;
            PREPARACAO:  next_estado = ESPERA;
            ESPERA: begin
                // A jogada arriving on the same cycle as the timeout wins.
                if (jogada_feita) begin
                    next_estado = REGISTRA;
                end else if (fimT && TIMEOUT_EN) begin
                    next_estado = FIM_TIMEOUT;
                end
            end
            REGISTRA:    next_estado = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    next_estado = FIM_ERRO;
                end else if (fimC) begin
                    next_estado = FIM_ACERTO;
                end else begin
                    next_estado = PROXIMO;
                end
            end
            PROXIMO:     next_estado = ESPERA;
            FIM_ACERTO,
            FIM_ERRO,
            FIM_TIMEOUT: if (iniciar) next_estado = PREPARACAO;
            // Unused codes recover to inicial.
            default:     next_estado = INICIAL;
        endcase
    end

    // Output decode
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        conta     = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA:     conta     = 1'b1;
            REGISTRA:   registraR = 1'b1;
            PROXIMO:    contaC    = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule : unidade_controle

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle
//   Directed bench for the game control unit. Two instances share inputs:
//   dut has the timeout enabled, dut_nt has it disabled.
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada_feita, igual, fimC, fimT;
    logic       zeraC, contaC, zeraR, registraR, conta;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic       zeraC_n, contaC_n, zeraR_n, registraR_n, conta_n;
    logic       pronto_n, acertou_n, errou_n, timeout_n;
    logic [3:0] db_estado_n;

    int errors = 0;
    int checks = 0;

    // Output vector order: zeraC contaC zeraR registraR conta pronto acertou errou timeout
    localparam logic [8:0] O_INI  = 9'b000000000;
    localparam logic [8:0] O_PREP = 9'b101000000;
    localparam logic [8:0] O_ESP  = 9'b000010000;
    localparam logic [8:0] O_REG  = 9'b000100000;
    localparam logic [8:0] O_CMP  = 9'b000000000;
    localparam logic [8:0] O_PROX = 9'b010000000;
    localparam logic [8:0] O_ACE  = 9'b000001100;
    localparam logic [8:0] O_ERR  = 9'b000001010;
    localparam logic [8:0] O_TMO  = 9'b000001011;

    unidade_controle #(.TIMEOUT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .fimT(fimT),
        .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
        .conta(conta), .pronto(pronto), .acertou(acertou), .errou(errou),
        .timeout(timeout), .db_estado(db_estado)
    );

    unidade_controle #(.TIMEOUT_EN(1'b0)) dut_nt (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .fimT(fimT),
        .zeraC(zeraC_n), .contaC(contaC_n), .zeraR(zeraR_n), .registraR(registraR_n),
        .conta(conta_n), .pronto(pronto_n), .acertou(acertou_n), .errou(errou_n),
        .timeout(timeout_n), .db_estado(db_estado_n)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] outs();
        return {zeraC, contaC, zeraR, registraR, conta, pronto, acertou, errou, timeout};
    endfunction

    function automatic logic [8:0] outs_n();
        return {zeraC_n, contaC_n, zeraR_n, registraR_n, conta_n,
                pronto_n, acertou_n, errou_n, timeout_n};
    endfunction

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        iniciar = 0; jogada_feita = 0; igual = 0; fimC = 0; fimT = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    // Reset, then pulse iniciar and walk into espera.
    task automatic go_espera();
        do_reset();
        iniciar = 1;
        step();
        iniciar = 0;
        step();
    endtask

    // One jogada from espera through comparacao into the following state.
    task automatic one_jogada(input logic ig, input logic fc);
        jogada_feita = 1; igual = ig; fimC = fc;
        step();             // registra
        jogada_feita = 0;
        step();             // comparacao
        step();             // proximo / fim_*
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (db_estado !== 4'h0) begin
            errors++; $display("FAIL reset_state: got %h want 0", db_estado);
        end
        checks++;
        if (outs() !== O_INI) begin
            errors++; $display("FAIL reset_outs: got %b want %b", outs(), O_INI);
        end
        jogada_feita = 1;   // ignored outside espera
        step();
        jogada_feita = 0;
        checks++;
        if (db_estado !== 4'h0) begin
            errors++; $display("FAIL inicial_hold: got %h want 0", db_estado);
        end
    endtask

    task automatic test_start();
        do_reset();
        iniciar = 1;
        step();
        iniciar = 0;
        checks++;
        if (db_estado !== 4'h1 || outs() !== O_PREP) begin
            errors++; $display("FAIL start_prep: got %h/%b want 1/%b", db_estado, outs(), O_PREP);
        end
        step();
        checks++;
        if (db_estado !== 4'h2 || outs() !== O_ESP) begin
            errors++; $display("FAIL start_espera: got %h/%b want 2/%b", db_estado, outs(), O_ESP);
        end
        step();
        checks++;
        if (db_estado !== 4'h2) begin
            errors++; $display("FAIL espera_hold: got %h want 2", db_estado);
        end
    endtask

    task automatic test_full_game();
        int prox_count = 0;
        go_espera();
        for (int i = 0; i < 16; i++) begin
            jogada_feita = 1; igual = 1; fimC = (i == 15);
            step();
            jogada_feita = 0;
            if (i == 0) begin
                checks++;
                if (db_estado !== 4'h4 || outs() !== O_REG) begin
                    errors++; $display("FAIL game_registra: got %h/%b want 4/%b", db_estado, outs(), O_REG);
                end
            end
            step();
            if (i == 0) begin
                checks++;
                if (db_estado !== 4'h5 || outs() !== O_CMP) begin
                    errors++; $display("FAIL game_comparacao: got %h/%b want 5/%b", db_estado, outs(), O_CMP);
                end
            end
            step();
            if (db_estado == 4'h6 && outs() == O_PROX) prox_count++;
            if (i < 15) step();   // proximo -> espera
        end
        checks++;
        if (prox_count !== 15) begin
            errors++; $display("FAIL game_proximo_count: got %0d want 15", prox_count);
        end
        checks++;
        if (db_estado !== 4'hA || outs() !== O_ACE) begin
            errors++; $display("FAIL game_acerto: got %h/%b want A/%b", db_estado, outs(), O_ACE);
        end
        clear_inputs();
        step();
        checks++;
        if (db_estado !== 4'hA) begin
            errors++; $display("FAIL acerto_hold: got %h want A", db_estado);
        end
    endtask

    task automatic test_error();
        int contac_count = 0;
        go_espera();
        for (int i = 0; i < 3; i++) begin
            one_jogada((i < 2), 1'b0);
            if (contaC) contac_count++;
            if (i < 2) step();
        end
        checks++;
        if (contac_count !== 2) begin
            errors++; $display("FAIL error_contaC_count: got %0d want 2", contac_count);
        end
        checks++;
        if (db_estado !== 4'hE || outs() !== O_ERR) begin
            errors++; $display("FAIL error_state: got %h/%b want E/%b", db_estado, outs(), O_ERR);
        end
    endtask

    task automatic test_timeout();
        go_espera();
        fimT = 1;
        step();
        fimT = 0;
        checks++;
        if (db_estado !== 4'hC || outs() !== O_TMO) begin
            errors++; $display("FAIL timeout_state: got %h/%b want C/%b", db_estado, outs(), O_TMO);
        end
        checks++;
        if (db_estado_n !== 4'h2 || outs_n() !== O_ESP) begin
            errors++; $display("FAIL timeout_disabled: got %h/%b want 2/%b", db_estado_n, outs_n(), O_ESP);
        end
        iniciar = 1;   // restart from fim_timeout
        step();
        iniciar = 0;
        checks++;
        if (db_estado !== 4'h1 || outs() !== O_PREP) begin
            errors++; $display("FAIL timeout_restart: got %h/%b want 1/%b", db_estado, outs(), O_PREP);
        end
    endtask

    task automatic test_tie();
        go_espera();
        jogada_feita = 1; fimT = 1;
        step();
        jogada_feita = 0; fimT = 0;
        checks++;
        if (db_estado !== 4'h4 || timeout !== 1'b0) begin
            errors++; $display("FAIL tie_jogada_wins: got %h timeout=%b want 4 timeout=0", db_estado, timeout);
        end
    endtask

    task automatic test_reset_mid();
        go_espera();
        one_jogada(1'b1, 1'b0);
        checks++;
        if (db_estado !== 4'h6) begin
            errors++; $display("FAIL mid_reach_proximo: got %h want 6", db_estado);
        end
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (db_estado !== 4'h0 || outs() !== O_INI) begin
            errors++; $display("FAIL mid_reset: got %h/%b want 0/%b", db_estado, outs(), O_INI);
        end
    endtask

    task automatic test_restart();
        go_espera();
        one_jogada(1'b0, 1'b0);
        clear_inputs();
        step();
        checks++;
        if (db_estado !== 4'hE) begin
            errors++; $display("FAIL erro_hold: got %h want E", db_estado);
        end
        iniciar = 1;
        step();
        iniciar = 0;
        checks++;
        if (db_estado !== 4'h1 || outs() !== O_PREP) begin
            errors++; $display("FAIL erro_restart: got %h/%b want 1/%b", db_estado, outs(), O_PREP);
        end
        // iniciar in espera is ignored
        step();
        iniciar = 1;
        step();
        iniciar = 0;
        checks++;
        if (db_estado !== 4'h2) begin
            errors++; $display("FAIL iniciar_ignored: got %h want 2", db_estado);
        end
        // reset in a final state
        one_jogada(1'b0, 1'b0);
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (db_estado !== 4'h0 || outs() !== O_INI) begin
            errors++; $display("FAIL final_reset: got %h/%b want 0/%b", db_estado, outs(), O_INI);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_start();
        test_full_game();
        test_error();
        test_timeout();
        test_tie();
        test_reset_mid();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_unidade_controle

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter: TIMEOUT_EN, default 1, when 0 fimT is ignored and espera never times out.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iniciar  input  1  start request; level-sampled.
REQ-005 jogada_feita  input  1  one-cycle pulse from datapath edge detector.
REQ-006 igual  input  1  datapath comparator result, ROM word == registered jogada.
REQ-007 fimC  input  1  datapath address counter at last position (15).
REQ-008 fimT  input  1  datapath timeout counter terminal count.
REQ-009 zeraC  output  1  clear address counter and timeout counter.
REQ-010 contaC  output  1  increment address counter.
REQ-011 zeraR  output  1  clear jogada register.
REQ-012 registraR  output  1  load jogada register from chaves.
REQ-013 conta  output  1  enable timeout counter.
REQ-014 pronto  output  1  game finished.
REQ-015 acertou  output  1  finished, all 16 jogadas correct.
REQ-016 errou  output  1  finished by wrong jogada or timeout.
REQ-017 timeout  output  1  finished by timeout.
REQ-018 db_estado  output  4  current state code, debug.

Function
REQ-019 Moore FSM; every output a function of the current state only.
REQ-020 State codes: inicial 0x0, preparacao 0x1, espera 0x2, registra 0x4, comparacao 0x5, proximo 0x6, fim_acerto 0xA, fim_erro 0xE, fim_timeout 0xC; unused codes -> inicial next cycle.
REQ-021 inicial: all control outputs 0; iniciar=1 -> preparacao, else stay.
REQ-022 preparacao: zeraC=1, zeraR=1; unconditional -> espera (iniciar to espera latency = 2 cycles).
REQ-023 espera: conta=1; jogada_feita=1 -> registra; else fimT=1 and TIMEOUT_EN=1 -> fim_timeout; else stay.
REQ-024 espera, jogada_feita and fimT same cycle: jogada_feita wins -> registra.
REQ-025 registra: registraR=1; unconditional -> comparacao.
REQ-026 comparacao: igual=0 -> fim_erro; igual=1 and fimC=1 -> fim_acerto; igual=1 and fimC=0 -> proximo.
REQ-027 proximo: contaC=1; unconditional -> espera.
REQ-028 fim_acerto: pronto=1, acertou=1; fim_erro: pronto=1, errou=1; fim_timeout: pronto=1, errou=1, timeout=1.
REQ-029 Final states hold until iniciar=1 -> preparacao (restart without reset).
REQ-030 jogada_feita outside espera is ignored; iniciar outside inicial/final states is ignored.
REQ-031 db_estado equals the REQ-020 code of the current state every cycle.

Reset
REQ-032 reset=1 at a rising edge forces inicial, overriding every transition, including mid-game and in final states.
REQ-033 Cycle after reset: zeraC, contaC, zeraR, registraR, conta, pronto, acertou, errou, timeout all 0; db_estado=0x0.
REQ-034 No asynchronous path from reset to state or outputs.

Structure
REQ-035 State code constants (REQ-020) live in the shared package unidade_controle_pkg, also used by the top-level debug display decoding.
REQ-036 Single module, three sections: state register, next-state logic, output decode; no sub-module.

Verification
REQ-037 Reset then iniciar=1 one cycle -> db_estado 0x0 -> 0x1 (zeraC=zeraR=1) -> 0x2 (conta=1).
REQ-038 Full correct game: 16 jogada_feita pulses, igual=1, fimC=1 on the 16th -> 15 passes through 0x6 (contaC=1 each), ends 0xA, pronto=acertou=1, errou=0.
REQ-039 igual=0 on 3rd jogada -> 0x5 -> 0xE, pronto=errou=1, timeout=0; contaC pulsed exactly twice.
REQ-040 In espera, fimT=1 with no jogada -> 0xC, pronto=errou=timeout=1; with TIMEOUT_EN=0 -> stays 0x2.
REQ-041 jogada_feita and fimT together in espera -> 0x4 next cycle, no timeout.
REQ-042 reset=1 while in 0x6 -> 0x0 next cycle, all outputs 0; iniciar in 0xE -> 0x1, flags cleared.
